// File: rtl/mem_fetch_unit_if.sv
// Memory request/acknowledge bundle between the fetch unit and memory.
// master: drives mem_req/mem_rnw/mem_addr/mem_wdata; slave: returns mem_rdata/mem_ack.
interface mem_fetch_unit_if #(
    parameter int DW = 8
);
    logic          mem_req;
    logic          mem_rnw;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport master (
        output mem_req, mem_rnw, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_rnw, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_fetch_unit.sv
// Datapath front end: PC/MAR/MBR/IR, bus drive, memory handshake with timeout, WMFC stall.
// Ports: CLK, reset_n, bus_in/bus_out/bus_oe, control lines, out_IR, stall, mem (master), mem_err, proto_err.
module mem_fetch_unit #(
    parameter int                DW       = 8,
    parameter logic [DW-1:0]     PC_RESET = '0,
    parameter int                TIMEOUT  = 16,
    parameter int                CW       = 5
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic [DW-1:0] bus_in,
    output logic [DW-1:0] bus_out,
    output logic          bus_oe,
    input  logic          pc_out,
    input  logic          increment,
    input  logic          MAR_in,
    input  logic          MBR_in,
    input  logic          MBR_out,
    input  logic          IR_in,
    input  logic          rnw,
    input  logic          WMFC,
    output logic [DW-1:0] out_IR,
    output logic          stall,
    mem_fetch_unit_if.master mem,
    output logic          mem_err,
    output logic          proto_err
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [DW-1:0] r_pc;
    logic [DW-1:0] r_mar;
    logic [DW-1:0] r_mbr;
    logic [DW-1:0] r_ir;
    logic [CW-1:0] r_cnt;
    logic          r_rnw;
    logic          r_merr;
    logic          r_perr;
    logic          w_start;
    logic          w_ack;
    logic          w_tmo;
    logic          w_mfc;

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_ack   = 1'b0;
        w_tmo   = 1'b0;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (MAR_in) begin
                    w_next  = S_REQ;
                    w_start = 1'b1;
                end
            end
            S_REQ: begin
                if (mem.mem_ack) begin
                    w_next = S_DONE;
                    w_ack  = 1'b1;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_next = S_DONE;
                    w_tmo  = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // PC takes priority on a bus conflict; the conflict is flagged below.
    always_comb begin
        bus_out = '0;
        bus_oe  = 1'b0;
        if (pc_out) begin
            bus_out = r_pc;
            bus_oe  = 1'b1;
        end else if (MBR_out) begin
            bus_out = r_mbr;
            bus_oe  = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_pc    <= PC_RESET;
            r_mar   <= '0;
            r_mbr   <= '0;
            r_ir    <= '0;
            r_cnt   <= '0;
            r_rnw   <= 1'b1;
            r_merr  <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (increment)
                r_pc <= r_pc + 1'b1;
            if (IR_in)
                r_ir <= bus_in;
            if (w_start) begin
                r_mar <= bus_in;
                r_rnw <= rnw;
                r_cnt <= '0;
            end
            if (r_state == S_REQ && !w_ack && !w_tmo)
                r_cnt <= r_cnt + 1'b1;
            // MBR belongs to the memory while an access is in flight.
            if (MBR_in && r_state != S_REQ)
                r_mbr <= bus_in;
            if (w_ack && r_rnw)
                r_mbr <= mem.mem_rdata;
            if (w_tmo) begin
                r_merr <= 1'b1;
                if (r_rnw)
                    r_mbr <= '1;
            end
            if ((MAR_in && r_state == S_REQ) || (pc_out && MBR_out))
                r_perr <= 1'b1;
        end
    end

    assign w_mfc         = (r_state == S_DONE);
    assign stall         = WMFC & ~w_mfc;
    assign out_IR        = r_ir;
    assign mem.mem_req   = (r_state == S_REQ);
    assign mem.mem_rnw   = r_rnw;
    assign mem.mem_addr  = r_mar;
    assign mem.mem_wdata = r_mbr;
    assign mem_err       = r_merr;
    assign proto_err     = r_perr;
endmodule

// File: tb/tb_mem_fetch_unit.sv
// Directed bench for mem_fetch_unit: vector table plus hand sequences.
// Inputs change just after the falling edge; outputs are checked 1ns later.
module tb_mem_fetch_unit;
    logic       CLK = 1'b0;
    logic       reset_n;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       pc_out, increment, MAR_in, MBR_in, MBR_out, IR_in, rnw, WMFC;
    logic [7:0] out_IR;
    logic       stall, mem_err, proto_err;

    int errors = 0;
    int checks = 0;

    mem_fetch_unit_if #(.DW(8)) mif ();

    mem_fetch_unit #(
        .DW(8), .PC_RESET(8'h10), .TIMEOUT(16), .CW(5)
    ) dut (
        .CLK(CLK), .reset_n(reset_n),
        .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
        .pc_out(pc_out), .increment(increment), .MAR_in(MAR_in),
        .MBR_in(MBR_in), .MBR_out(MBR_out), .IR_in(IR_in),
        .rnw(rnw), .WMFC(WMFC), .out_IR(out_IR), .stall(stall),
        .mem(mif), .mem_err(mem_err), .proto_err(proto_err)
    );

    always #5 CLK = ~CLK;

    // ctl = {rst_n,pc_out,inc,mar_in,mbr_in,mbr_out,ir_in,rnw,wmfc,ack}
    // ef  = {bus_oe,stall,mem_req,mem_rnw,mem_err,proto_err}
    typedef struct {
        logic [9:0] ctl;
        logic [7:0] bus;
        logic [7:0] rdata;
        logic [7:0] e_bus;
        logic [5:0] ef;
        logic [7:0] e_addr;
        logic [7:0] e_wdata;
        logic [7:0] e_ir;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_in();
        reset_n = 1'b1; pc_out = 0; increment = 0; MAR_in = 0;
        MBR_in = 0; MBR_out = 0; IR_in = 0; rnw = 1; WMFC = 0;
        bus_in = 8'h00; mif.mem_ack = 0; mif.mem_rdata = 8'h00;
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    initial begin
        int n;
        idle_in();
        reset_n = 1'b0;
        tick(); tick();

        tbl[0]  = '{10'b1000000110, 8'h00, 8'h00, 8'h00, 6'b010100, 8'h00, 8'h00, 8'h00};
        tbl[1]  = '{10'b1111000100, 8'h10, 8'h00, 8'h10, 6'b100100, 8'h00, 8'h00, 8'h00};
        tbl[2]  = '{10'b1000000110, 8'h00, 8'h00, 8'h00, 6'b011100, 8'h10, 8'h00, 8'h00};
        tbl[3]  = '{10'b1000000110, 8'h00, 8'h00, 8'h00, 6'b011100, 8'h10, 8'h00, 8'h00};
        tbl[4]  = '{10'b1000000111, 8'h00, 8'hA5, 8'h00, 6'b011100, 8'h10, 8'h00, 8'h00};
        tbl[5]  = '{10'b1000000110, 8'h00, 8'h00, 8'h00, 6'b000100, 8'h10, 8'hA5, 8'h00};
        tbl[6]  = '{10'b1000011100, 8'hA5, 8'h00, 8'hA5, 6'b100100, 8'h10, 8'hA5, 8'h00};
        tbl[7]  = '{10'b1100000100, 8'h11, 8'h00, 8'h11, 6'b100100, 8'h10, 8'hA5, 8'hA5};
        tbl[8]  = '{10'b1000100100, 8'h3C, 8'h00, 8'h00, 6'b000100, 8'h10, 8'hA5, 8'hA5};
        tbl[9]  = '{10'b1001000000, 8'h20, 8'h00, 8'h00, 6'b000100, 8'h10, 8'h3C, 8'hA5};
        tbl[10] = '{10'b1000000011, 8'h00, 8'hEE, 8'h00, 6'b011000, 8'h20, 8'h3C, 8'hA5};
        tbl[11] = '{10'b1000000010, 8'h00, 8'h00, 8'h00, 6'b000000, 8'h20, 8'h3C, 8'hA5};
        tbl[12] = '{10'b1000000101, 8'h00, 8'h77, 8'h00, 6'b000000, 8'h20, 8'h3C, 8'hA5};
        tbl[13] = '{10'b1000000110, 8'h00, 8'h00, 8'h00, 6'b000000, 8'h20, 8'h3C, 8'hA5};

        for (int i = 0; i < 14; i++) begin
            {reset_n, pc_out, increment, MAR_in, MBR_in, MBR_out,
             IR_in, rnw, WMFC, mif.mem_ack} = tbl[i].ctl;
            bus_in        = tbl[i].bus;
            mif.mem_rdata = tbl[i].rdata;
            #1;
            chk($sformatf("v%0d bus_out", i), bus_out, tbl[i].e_bus);
            chk($sformatf("v%0d flags", i),
                {2'b00, bus_oe, stall, mif.mem_req, mif.mem_rnw, mem_err, proto_err},
                {2'b00, tbl[i].ef});
            chk($sformatf("v%0d mem_addr", i), mif.mem_addr, tbl[i].e_addr);
            chk($sformatf("v%0d mem_wdata", i), mif.mem_wdata, tbl[i].e_wdata);
            chk($sformatf("v%0d out_IR", i), out_IR, tbl[i].e_ir);
            tick();
        end

        // Timeout on a read: 16 request cycles, then all-ones and mem_err.
        idle_in();
        MAR_in = 1; bus_in = 8'h30;
        tick();
        idle_in();
        WMFC = 1;
        #1;
        n = 0;
        while (mif.mem_req && n < 40) begin
            n++;
            tick();
            #1;
        end
        chk("tmo req_cycles", 8'(n), 8'd16);
        chk("tmo mem_addr", mif.mem_addr, 8'h30);
        chk("tmo mbr", mif.mem_wdata, 8'hFF);
        chk("tmo mem_err", {7'b0, mem_err}, 8'h01);
        chk("tmo stall", {7'b0, stall}, 8'h00);
        tick();

        // PC wrap: PC is 8'h11, step it up to 8'hFF.
        idle_in();
        increment = 1;
        for (int i = 0; i < 8'hEE; i++) tick();
        idle_in();
        pc_out = 1; increment = 1;
        #1;
        chk("wrap old_pc", bus_out, 8'hFF);
        tick();
        idle_in();
        pc_out = 1; MBR_out = 1;
        #1;
        chk("wrap new_pc", bus_out, 8'h00);
        chk("conflict oe", {7'b0, bus_oe}, 8'h01);
        chk("conflict perr_pre", {7'b0, proto_err}, 8'h00);
        tick();
        idle_in();
        #1;
        chk("conflict perr", {7'b0, proto_err}, 8'h01);

        // Reset clears sticky flags, then MAR_in while busy.
        reset_n = 0;
        tick();
        idle_in();
        #1;
        chk("rst perr", {6'b0, proto_err, mem_err}, 8'h00);
        MAR_in = 1; bus_in = 8'h40;
        tick();
        idle_in();
        MAR_in = 1; bus_in = 8'h55;
        tick();
        idle_in();
        mif.mem_ack = 1; mif.mem_rdata = 8'h5A;
        #1;
        chk("busy mar", mif.mem_addr, 8'h40);
        chk("busy perr", {7'b0, proto_err}, 8'h01);
        tick();
        idle_in();
        #1;
        chk("busy rd mbr", mif.mem_wdata, 8'h5A);

        // Reset in the second request cycle; the late ack must be dropped.
        reset_n = 0;
        tick();
        idle_in();
        MAR_in = 1; bus_in = 8'h60;
        tick();
        idle_in();
        tick();
        idle_in();
        reset_n = 0;
        #1;
        chk("midrst req_before", {7'b0, mif.mem_req}, 8'h01);
        tick();
        idle_in();
        mif.mem_ack = 1; mif.mem_rdata = 8'h99;
        tick();
        idle_in();
        WMFC = 1;
        #1;
        chk("midrst req", {7'b0, mif.mem_req}, 8'h00);
        chk("midrst mbr", mif.mem_wdata, 8'h00);
        chk("midrst stall", {7'b0, stall}, 8'h01);
        chk("midrst mar", mif.mem_addr, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_fetch_unit.md
Name: mem_fetch_unit

Overview:
- Datapath front end directly downstream of the microprogrammed control unit; consumes its control-signal lines (pc_out, increment, WMFC, rnw, MAR_in, MBR_out, IR_in) and feeds the instruction register value back to the control unit's decoder.
- Holds PC, MAR, MBR and IR.
- Runs a single-outstanding request/acknowledge handshake to an external memory with a timeout.
- Generates the stall that freezes microsequencing while WMFC is asserted and the memory function is incomplete.

Parameters:
- DW, 8, data/address width of bus, PC, MAR, MBR, IR.
- PC_RESET, 8'h00, PC value after reset.
- TIMEOUT, 16, max cycles in REQ without mem_ack before abort (≥2).
- CW, 5, width of timeout counter (must hold TIMEOUT-1).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- reset_n  in  1  synchronous active-low reset, sampled on rising CLK.
- bus_in  in  DW  shared data bus value seen this cycle.
- bus_out  out  DW  value this block drives onto the bus.
- bus_oe  out  1  bus_out valid/driving.
- pc_out, increment, MAR_in, MBR_in, MBR_out, IR_in, rnw, WMFC  in  1 each  control-signal lines from the control unit (rnw: 1 = read, 0 = write).
- out_IR  out  DW  IR contents, to the control unit's decoder.
- stall  out  1  hold the control unit's CAR/CBR this cycle.
- mem_req  out  1  memory request.
- mem_rnw  out  1  latched direction.
- mem_addr  out  DW  = MAR.
- mem_wdata  out  DW  = MBR.
- mem_rdata  in  DW  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse.
- mem_err  out  1  sticky: timeout occurred.
- proto_err  out  1  sticky: MAR_in during REQ, or pc_out and MBR_out together.

Behaviour:
- Reset (reset_n=0 at edge): PC=PC_RESET; MAR=MBR=IR=0; FSM=IDLE; timeout counter=0; mem_req=0; mem_rnw=1; mem_err=proto_err=0; mfc=0. Reset overrides every other input, including mid-REQ; a later mem_ack for the aborted request is ignored.
- Bus drive (combinational):
  - pc_out → bus_out=PC, bus_oe=1.
  - else MBR_out → bus_out=MBR, bus_oe=1.
  - else bus_out=0, bus_oe=0.
  - pc_out & MBR_out: PC wins; proto_err set next edge.
- PC: increment → PC<=PC+1 mod 2^DW (8'hFF → 8'h00). pc_out and increment in the same cycle: bus shows the old PC.
- IR_in → IR<=bus_in.
- MBR_in → MBR<=bus_in, only in IDLE/DONE. Ignored in REQ.
- FSM state IDLE:
  - mfc=0.
  - MAR_in → MAR<=bus_in, mem_rnw<=rnw, counter<=0, go REQ.
- FSM state REQ:
  - mem_req=1, mem_addr=MAR. Access starts the cycle after MAR_in (1-cycle latency).
  - mem_ack:
    - Read: MBR<=mem_rdata.
    - Write: memory consumes mem_wdata.
    - Then go DONE, mfc<=1.
  - No ack and counter==TIMEOUT-1: go DONE, mfc<=1, mem_err<=1; on a read MBR<=all-ones.
  - Otherwise counter++.
  - MAR_in during REQ: ignored, proto_err<=1.
- FSM state DONE:
  - mfc=1, mem_req=0.
  - MAR_in → new access exactly as from IDLE (mfc<=0).
  - No MAR_in → stay in DONE.
- stall = WMFC & ~mfc (combinational). WMFC in IDLE with no access pending also stalls; the microcode must not do this.
- Minimum read: MAR_in cycle t; mem_req from t+1; ack at t+1 → MBR valid and stall=0 at t+2.
- mem_ack outside REQ: ignored.
- Sticky error flags clear only on reset.

Test Plan:
- Reset: reset_n=0 one edge with PC_RESET=8'h10 → PC=8'h10, mem_req=0, bus_oe=0, stall=WMFC; all registers 0.
- Fetch: pc_out+MAR_in+increment, then WMFC; ack at 3rd REQ cycle with rdata=8'hA5 → mem_addr=8'h10, mem_req high 3 cycles, stall high until ack edge, MBR=8'hA5, PC=8'h11; MBR_out+IR_in → out_IR=8'hA5.
- Write: bus 8'h3C with MBR_in; bus 8'h20 with MAR_in, rnw=0; ack after 1 cycle → mem_rnw=0, mem_addr=8'h20, mem_wdata=8'h3C, mem_err=0.
- Timeout: read with no ack, TIMEOUT=16 → mem_req high exactly 16 cycles, then DONE, MBR=8'hFF, mem_err=1, stall released.
- PC wrap and conflict: PC=8'hFF, increment → 8'h00; pc_out+MBR_out → bus_out=PC, proto_err=1; MAR_in during REQ → MAR unchanged, proto_err=1.
- Reset mid-REQ: reset_n=0 at 2nd REQ cycle, ack the next cycle → FSM IDLE, MBR unchanged at 0, mem_req=0.
